scarv_cop_dispatch: RTL and testbench

Sequencing stage directly upstream of the coprocessor instruction decoder.
- Accepts 32-bit encodings from the host CPU over a valid/ready handshake and registers them.
- Drives the decoder's encoded input and consumes its exception, class, subclass and init outputs.
- Issues the instruction to the functional units, runs the 16-register init sequence, and returns a status response to the CPU.

---
 rtl/scarv_cop_dispatch_pkg.sv | 34 +++
 rtl/scarv_cop_dispatch.sv | 151 +++++++++++++++
 tb/tb_scarv_cop_dispatch.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scarv_cop_dispatch_pkg.sv
// Shared types for the coprocessor dispatch stage: FSM state encoding,
// response status codes and instruction class codes.
`default_nettype none

package scarv_cop_dispatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_INIT   = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  // Codes 4..7 are reserved.
  typedef enum logic [2:0] {
    STATUS_OK      = 3'd0,
    STATUS_ILLEGAL = 3'd1,
    STATUS_FU_EXC  = 3'd2,
    STATUS_TIMEOUT = 3'd3
  } status_e;

  localparam logic [3:0] SCARV_COP_ICLASS_PACKED_ARITH = 4'd1;
  localparam logic [3:0] SCARV_COP_ICLASS_TWIDDLE      = 4'd2;
  localparam logic [3:0] SCARV_COP_ICLASS_LOADSTORE    = 4'd3;
  localparam logic [3:0] SCARV_COP_ICLASS_RANDOM       = 4'd4;
  localparam logic [3:0] SCARV_COP_ICLASS_MOVE         = 4'd5;
  localparam logic [3:0] SCARV_COP_ICLASS_MP           = 4'd6;
  localparam logic [3:0] SCARV_COP_ICLASS_BITWISE      = 4'd7;

endpackage

`default_nettype wire

// File: rtl/scarv_cop_dispatch.sv
// Coprocessor dispatch: accepts CPU instructions, sequences decode/issue/init
// and returns a status response. SCARV_COP_PERF_CNT_EN adds a retired-OK counter.
`default_nettype none

module scarv_cop_dispatch
  import scarv_cop_dispatch_pkg::*;
#(
  parameter int NUM_CPRS   = 16,
  parameter int FU_TIMEOUT = 1023
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cpu_insn_req,
  output logic        cop_insn_ack,
  input  logic [31:0] cpu_insn_enc,
  output logic [31:0] id_encoded,
  input  logic        id_exception,
  input  logic [3:0]  id_class,
  input  logic [4:0]  id_subclass,
  input  logic        id_cprs_init,
  output logic        fu_issue,
  output logic [3:0]  fu_class,
  output logic [4:0]  fu_subclass,
  input  logic        fu_done,
  input  logic        fu_exception,
  output logic        crf_init_wen,
  output logic [3:0]  crf_init_addr,
  output logic        cop_insn_rsp,
  input  logic        cpu_insn_rsp_ack,
  output logic [2:0]  cop_rsp_status
`ifdef SCARV_COP_PERF_CNT_EN
  ,
  output logic [31:0] cop_perf_retired
`endif
);

  localparam logic [9:0] TMO_LAST  = 10'(FU_TIMEOUT);
  localparam logic [9:0] INIT_LAST = 10'(NUM_CPRS - 1);

  state_e      state_q, state_d;
  status_e     status_q, status_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [31:0] enc_q, enc_d;
  logic [3:0]  class_q, class_d;
  logic [4:0]  sub_q, sub_d;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q  <= ST_IDLE;
      status_q <= STATUS_OK;
      cnt_q    <= '0;
      enc_q    <= '0;
      class_q  <= '0;
      sub_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
      enc_q    <= enc_d;
      class_q  <= class_d;
      sub_q    <= sub_d;
    end
  end

  // One counter serves both the WAIT timeout and the INIT address sequence.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    enc_d    = enc_q;
    class_d  = class_q;
    sub_d    = sub_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_insn_req) begin
          enc_d   = cpu_insn_enc;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (id_exception) begin
          status_d = STATUS_ILLEGAL;
          state_d  = ST_RESP;
        end else if (id_cprs_init) begin
          cnt_d   = '0;
          state_d = ST_INIT;
        end else begin
          class_d = id_class;
          sub_d   = id_subclass;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (fu_done) begin
          status_d = fu_exception ? STATUS_FU_EXC : STATUS_OK;
          state_d  = ST_RESP;
        end else if (cnt_q == TMO_LAST) begin
          status_d = STATUS_TIMEOUT;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          cnt_d    = '0;
          status_d = STATUS_OK;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      ST_RESP: begin
        if (cpu_insn_rsp_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are masked by reset so an in-flight init write stops in the reset cycle.
  assign cop_insn_ack   = (state_q == ST_IDLE) && !g_reset;
  assign fu_issue       = (state_q == ST_ISSUE) && !g_reset;
  assign crf_init_wen   = (state_q == ST_INIT) && !g_reset;
  assign cop_insn_rsp   = (state_q == ST_RESP) && !g_reset;
  assign crf_init_addr  = cnt_q[3:0];
  assign cop_rsp_status = status_q;
  assign id_encoded     = enc_q;
  assign fu_class       = class_q;
  assign fu_subclass    = sub_q;

`ifdef SCARV_COP_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      perf_q <= '0;
    end else if ((state_q == ST_RESP) && cpu_insn_rsp_ack && (status_q == STATUS_OK)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign cop_perf_retired = perf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_scarv_cop_dispatch.sv
// Self-checking bench for scarv_cop_dispatch: per-transaction timeline model.
`default_nettype none
`timescale 1ns/1ps

module tb_scarv_cop_dispatch;
  import scarv_cop_dispatch_pkg::*;

  localparam int NUM_CPRS   = 16;
  localparam int FU_TIMEOUT = 1023;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        cpu_insn_req;
  logic        cop_insn_ack;
  logic [31:0] cpu_insn_enc;
  logic [31:0] id_encoded;
  logic        id_exception;
  logic [3:0]  id_class;
  logic [4:0]  id_subclass;
  logic        id_cprs_init;
  logic        fu_issue;
  logic [3:0]  fu_class;
  logic [4:0]  fu_subclass;
  logic        fu_done;
  logic        fu_exception;
  logic        crf_init_wen;
  logic [3:0]  crf_init_addr;
  logic        cop_insn_rsp;
  logic        cpu_insn_rsp_ack;
  logic [2:0]  cop_rsp_status;
`ifdef SCARV_COP_PERF_CNT_EN
  logic [31:0] cop_perf_retired;
`endif

  int checks   = 0;
  int failures = 0;
  int perf_exp = 0;

  always #5 g_clk = ~g_clk;

  scarv_cop_dispatch #(.NUM_CPRS(NUM_CPRS), .FU_TIMEOUT(FU_TIMEOUT)) dut (
    .g_clk            (g_clk),
    .g_reset          (g_reset),
    .cpu_insn_req     (cpu_insn_req),
    .cop_insn_ack     (cop_insn_ack),
    .cpu_insn_enc     (cpu_insn_enc),
    .id_encoded       (id_encoded),
    .id_exception     (id_exception),
    .id_class         (id_class),
    .id_subclass      (id_subclass),
    .id_cprs_init     (id_cprs_init),
    .fu_issue         (fu_issue),
    .fu_class         (fu_class),
    .fu_subclass      (fu_subclass),
    .fu_done          (fu_done),
    .fu_exception     (fu_exception),
    .crf_init_wen     (crf_init_wen),
    .crf_init_addr    (crf_init_addr),
    .cop_insn_rsp     (cop_insn_rsp),
    .cpu_insn_rsp_ack (cpu_insn_rsp_ack),
    .cop_rsp_status   (cop_rsp_status)
`ifdef SCARV_COP_PERF_CNT_EN
    ,
    .cop_perf_retired (cop_perf_retired)
`endif
  );

  // One instruction, from accept (cycle 0) to response handshake. The expected
  // timeline comes from the latency rules: illegal -> rsp at 2, init -> writes
  // at 2..2+N-1 and rsp at 2+N, otherwise issue at 2, WAIT from 3, rsp one
  // cycle after fu_done or after FU_TIMEOUT+1 WAIT cycles.
  task automatic run_insn(input logic [31:0] enc, input bit exc, input bit init,
                          input logic [3:0] cls, input logic [4:0] sub,
                          input int done_at, input bit fexc, input int delay);
    int issue_c, done_c, rsp_c, last_c;
    logic [2:0] st;
    bit exp_wen, in_wait;
    issue_c = -1;
    done_c  = -1;
    if (exc) begin
      rsp_c = 2; st = 3'd1;
    end else if (init) begin
      rsp_c = 2 + NUM_CPRS; st = 3'd0;
    end else begin
      issue_c = 2;
      if (done_at >= 0 && done_at <= FU_TIMEOUT) begin
        done_c = 3 + done_at; rsp_c = done_c + 1; st = fexc ? 3'd2 : 3'd0;
      end else begin
        rsp_c = 3 + FU_TIMEOUT + 1; st = 3'd3;
      end
    end
    last_c = rsp_c + delay;

    @(negedge g_clk);
    checks++;
    if (cop_insn_ack !== 1'b1) begin
      failures++; $display("FAIL idle_ack got=%b exp=1", cop_insn_ack);
    end
`ifdef SCARV_COP_PERF_CNT_EN
    checks++;
    if (cop_perf_retired !== 32'(perf_exp)) begin
      failures++; $display("FAIL perf_retired got=%0d exp=%0d", cop_perf_retired, perf_exp);
    end
`endif
    cpu_insn_req = 1'b1; cpu_insn_enc = enc;
    id_exception = exc; id_cprs_init = init; id_class = cls; id_subclass = sub;
    fu_done = 1'b0; fu_exception = 1'b0; cpu_insn_rsp_ack = 1'b0;

    for (int c = 1; c <= last_c; c++) begin
      @(negedge g_clk);
      checks++;
      if (cop_insn_ack !== 1'b0) begin
        failures++; $display("FAIL busy_ack c=%0d got=%b exp=0", c, cop_insn_ack);
      end
      checks++;
      if (id_encoded !== enc) begin
        failures++; $display("FAIL id_encoded c=%0d got=%h exp=%h", c, id_encoded, enc);
      end
      checks++;
      if (fu_issue !== (c == issue_c)) begin
        failures++; $display("FAIL fu_issue c=%0d got=%b exp=%b", c, fu_issue, (c == issue_c));
      end
      if (c == issue_c) begin
        checks++;
        if (fu_class !== cls || fu_subclass !== sub) begin
          failures++; $display("FAIL fu_class c=%0d got=%h/%h exp=%h/%h", c, fu_class, fu_subclass, cls, sub);
        end
      end
      exp_wen = init && !exc && c >= 2 && c < 2 + NUM_CPRS;
      checks++;
      if (crf_init_wen !== exp_wen) begin
        failures++; $display("FAIL crf_init_wen c=%0d got=%b exp=%b", c, crf_init_wen, exp_wen);
      end
      if (exp_wen) begin
        checks++;
        if (crf_init_addr !== 4'(c - 2)) begin
          failures++; $display("FAIL crf_init_addr c=%0d got=%0d exp=%0d", c, crf_init_addr, c - 2);
        end
      end
      checks++;
      if (cop_insn_rsp !== (c >= rsp_c)) begin
        failures++; $display("FAIL rsp_valid c=%0d got=%b exp=%b", c, cop_insn_rsp, (c >= rsp_c));
      end
      if (c >= rsp_c) begin
        checks++;
        if (cop_rsp_status !== st) begin
          failures++; $display("FAIL rsp_status c=%0d got=%0d exp=%0d", c, cop_rsp_status, st);
        end
      end
      // Requests and stray completions outside WAIT must be ignored.
      cpu_insn_req = 1'($urandom_range(0, 1));
      cpu_insn_enc = $urandom;
      in_wait = (issue_c > 0) && c >= 3 && c < rsp_c;
      if (in_wait) begin
        fu_done      = (c == done_c);
        fu_exception = (c == done_c) ? fexc : 1'($urandom_range(0, 1));
      end else begin
        fu_done      = ($urandom_range(0, 3) == 0);
        fu_exception = 1'($urandom_range(0, 1));
      end
      if (c == last_c)      cpu_insn_rsp_ack = 1'b1;
      else if (c >= rsp_c)  cpu_insn_rsp_ack = 1'b0;
      else                  cpu_insn_rsp_ack = 1'($urandom_range(0, 1));
    end
    if (st == 3'd0) perf_exp++;
  endtask

  task automatic test_reset();
    g_reset = 1'b1; cpu_insn_req = 1'b0; cpu_insn_enc = '0;
    id_exception = 1'b0; id_class = '0; id_subclass = '0; id_cprs_init = 1'b0;
    fu_done = 1'b0; fu_exception = 1'b0; cpu_insn_rsp_ack = 1'b0;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    checks++;
    if ({cop_insn_ack, fu_issue, crf_init_wen, cop_insn_rsp} !== 4'b0 ||
        id_encoded !== 32'd0 || fu_class !== 4'd0 || fu_subclass !== 5'd0 ||
        crf_init_addr !== 4'd0 || cop_rsp_status !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs got ack=%b iss=%b wen=%b rsp=%b enc=%h cls=%h sub=%h addr=%h st=%h exp all 0",
               cop_insn_ack, fu_issue, crf_init_wen, cop_insn_rsp, id_encoded, fu_class,
               fu_subclass, crf_init_addr, cop_rsp_status);
    end
    g_reset = 1'b0;
    #1;
    checks++;
    if (cop_insn_ack !== 1'b1) begin
      failures++; $display("FAIL reset_release_ack got=%b exp=1", cop_insn_ack);
    end
    perf_exp = 0;
  endtask

  task automatic test_normal();
    run_insn(32'h1234_5673, 1'b0, 1'b0, SCARV_COP_ICLASS_PACKED_ARITH, 5'd5, 3, 1'b0, 0);
    for (int i = 0; i < 12; i++)
      run_insn($urandom, 1'b0, 1'b0, 4'($urandom_range(1, 7)), 5'($urandom),
               $urandom_range(0, 20), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
  endtask

  task automatic test_illegal();
    run_insn($urandom, 1'b1, 1'b0, SCARV_COP_ICLASS_MOVE, 5'd3, 0, 1'b0, 0);
    run_insn($urandom, 1'b1, 1'b1, SCARV_COP_ICLASS_RANDOM, 5'd1, 0, 1'b0, 1);
  endtask

  task automatic test_init();
    run_insn($urandom, 1'b0, 1'b1, SCARV_COP_ICLASS_MP, 5'd0, 0, 1'b0, 0);
  endtask

  task automatic test_timeout();
    run_insn($urandom, 1'b0, 1'b0, SCARV_COP_ICLASS_TWIDDLE, 5'd9, -1, 1'b0, 0);
    run_insn($urandom, 1'b0, 1'b0, SCARV_COP_ICLASS_TWIDDLE, 5'd9, FU_TIMEOUT, 1'b0, 0);
    run_insn($urandom, 1'b0, 1'b0, SCARV_COP_ICLASS_BITWISE, 5'd2, FU_TIMEOUT - 1, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    run_insn($urandom, 1'b0, 1'b0, SCARV_COP_ICLASS_LOADSTORE, 5'd7, 1, 1'b0, 5);
    run_insn($urandom, 1'b1, 1'b0, SCARV_COP_ICLASS_LOADSTORE, 5'd7, 0, 1'b0, 5);
    run_insn($urandom, 1'b0, 1'b1, SCARV_COP_ICLASS_LOADSTORE, 5'd7, 0, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge g_clk);
    cpu_insn_req = 1'b1; cpu_insn_enc = $urandom;
    id_exception = 1'b0; id_cprs_init = 1'b1;
    fu_done = 1'b0; cpu_insn_rsp_ack = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge g_clk);
      cpu_insn_req = 1'b0;
    end
    checks++;
    if (crf_init_wen !== 1'b1 || crf_init_addr !== 4'd7) begin
      failures++; $display("FAIL mid_init_addr got wen=%b addr=%0d exp wen=1 addr=7", crf_init_wen, crf_init_addr);
    end
    g_reset = 1'b1;
    #1;
    checks++;
    if (crf_init_wen !== 1'b0 || cop_insn_rsp !== 1'b0 || fu_issue !== 1'b0) begin
      failures++; $display("FAIL reset_cycle_wen got wen=%b rsp=%b iss=%b exp 0", crf_init_wen, cop_insn_rsp, fu_issue);
    end
    @(negedge g_clk);
    checks++;
    if ({cop_insn_ack, fu_issue, crf_init_wen, cop_insn_rsp} !== 4'b0 ||
        id_encoded !== 32'd0 || crf_init_addr !== 4'd0 || cop_rsp_status !== 3'd0) begin
      failures++;
      $display("FAIL post_reset_outputs got ack=%b iss=%b wen=%b rsp=%b enc=%h addr=%h st=%h exp all 0",
               cop_insn_ack, fu_issue, crf_init_wen, cop_insn_rsp, id_encoded, crf_init_addr, cop_rsp_status);
    end
    g_reset = 1'b0; id_cprs_init = 1'b0; perf_exp = 0;
    #1;
    checks++;
    if (cop_insn_ack !== 1'b1) begin
      failures++; $display("FAIL post_reset_idle got ack=%b exp=1", cop_insn_ack);
    end
    repeat (3) begin
      @(negedge g_clk);
      checks++;
      if (cop_insn_rsp !== 1'b0 || crf_init_wen !== 1'b0) begin
        failures++; $display("FAIL no_rsp_after_reset got rsp=%b wen=%b exp 0", cop_insn_rsp, crf_init_wen);
      end
    end
  endtask

  task automatic test_perf();
    run_insn($urandom, 1'b0, 1'b0, SCARV_COP_ICLASS_PACKED_ARITH, 5'd1, 2, 1'b0, 0);
    run_insn($urandom, 1'b1, 1'b0, SCARV_COP_ICLASS_PACKED_ARITH, 5'd1, 0, 1'b0, 0);
    run_insn($urandom, 1'b0, 1'b1, SCARV_COP_ICLASS_PACKED_ARITH, 5'd1, 0, 1'b0, 0);
    run_insn($urandom, 1'b0, 1'b0, SCARV_COP_ICLASS_MOVE, 5'd4, 0, 1'b0, 2);
    // Final accept check also compares the retired count (3 here) when enabled.
    run_insn($urandom, 1'b1, 1'b0, SCARV_COP_ICLASS_MOVE, 5'd4, 0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_illegal();
    test_init();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
